// File: rtl/iris_fw_meta_streamer_if.sv
// Byte-stream handshake bundle between the metadata streamer and the telemetry mux.
// Master drives data/valid, slave returns ready.
interface iris_fw_meta_streamer_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/iris_fw_meta_streamer.sv
// FW version block that streams a checksummed metadata frame on request.
// Frame: MAGIC, MAJ, MIN, PATCH, build ID (MSB first), CSUM.
module iris_fw_meta_streamer #(
   parameter logic [7:0]  FW_VER_MAJ     = 8'd11,
   parameter logic [7:0]  FW_VER_MIN     = 8'd0,
   parameter logic [7:0]  FW_VER_PATCH   = 8'd0,
   parameter int unsigned BUILD_ID_BYTES = 4,
   parameter logic [63:0] BUILD_ID       = 64'hDEADBEEF,
   parameter logic [7:0]  MAGIC          = 8'hA5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req,
   iris_fw_meta_streamer_if.master        m,
   output logic                           busy,
   output logic                           done,
   output logic [7:0]                     frames_sent,
   output logic [7:0]                     major,
   output logic [7:0]                     minor,
   output logic [7:0]                     patch
);

   localparam int unsigned N    = 5 + BUILD_ID_BYTES;
   localparam logic [3:0]  LAST = 4'(N - 1);

   typedef logic [12:0][7:0] frame_t;
   typedef enum logic {IDLE, SEND} state_t;

   // Whole frame, checksum included, is fixed at elaboration.
   function automatic frame_t build_frame();
      frame_t     f;
      logic [7:0] s;
      int         sh;
      f    = '0;
      f[0] = MAGIC;
      f[1] = FW_VER_MAJ;
      f[2] = FW_VER_MIN;
      f[3] = FW_VER_PATCH;
      s    = FW_VER_MAJ + FW_VER_MIN + FW_VER_PATCH;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(BUILD_ID_BYTES)) begin
            sh       = (int'(BUILD_ID_BYTES) - 1 - k) * 8;
            f[4 + k] = 8'(BUILD_ID >> sh);
            s        = s + f[4 + k];
         end
      end
      f[N - 1] = s;
      return f;
   endfunction

   localparam frame_t FRAME = build_frame();

   state_t     state_q;
   logic [3:0] idx_q;
   logic [7:0] data_q;
   logic       valid_q;
   logic       done_q;
   logic       pend_q;
   logic [7:0] cnt_q;
   logic       accept;
   logic       last;

   assign accept = valid_q & m.m_ready;
   assign last   = (idx_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= SEND;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  data_q  <= MAGIC;
               end
            end
            SEND: begin
               if (accept && last) begin
                  done_q <= 1'b1;
                  cnt_q  <= cnt_q + 8'd1;
                  pend_q <= 1'b0;
                  idx_q  <= '0;
                  // A queued or coincident request restarts with no idle gap.
                  if (pend_q || req) begin
                     data_q <= MAGIC;
                  end else begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     data_q  <= '0;
                  end
               end else begin
                  if (req) pend_q <= 1'b1;
                  if (accept) begin
                     idx_q  <= idx_q + 4'd1;
                     data_q <= FRAME[idx_q + 4'd1];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m.m_data    = data_q;
   assign m.m_valid   = valid_q;
   assign busy        = (state_q == SEND);
   assign done        = done_q;
   assign frames_sent = cnt_q;
   assign major       = FW_VER_MAJ;
   assign minor       = FW_VER_MIN;
   assign patch       = FW_VER_PATCH;

endmodule

// File: tb/tb_iris_fw_meta_streamer.sv
// Scoreboard bench for iris_fw_meta_streamer: default build and a 1-byte build-ID build.
// Stimulus pushes expected bytes; negedge monitors pop and compare on each handshake.
module tb_iris_fw_meta_streamer;

   logic       clk;
   logic       rst_n;
   logic       req_a;
   logic       req_b;
   logic       busy_a, done_a, busy_b, done_b;
   logic [7:0] fs_a, fs_b;
   logic [7:0] maj_a, min_a, pat_a, maj_b, min_b, pat_b;

   int n_cmp = 0;
   int n_err = 0;
   int acc_a = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   logic [7:0] exp_qa[$];
   logic [7:0] exp_qb[$];

   logic [7:0] FR_A [9] = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'hDE,
                            8'hAD, 8'hBE, 8'hEF, 8'h43};
   logic [7:0] FR_B [6] = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h7F, 8'h8A};

   iris_fw_meta_streamer_if ifa ();
   iris_fw_meta_streamer_if ifb ();

   iris_fw_meta_streamer dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .m(ifa.master),
      .busy(busy_a), .done(done_a), .frames_sent(fs_a),
      .major(maj_a), .minor(min_a), .patch(pat_a)
   );

   iris_fw_meta_streamer #(
      .BUILD_ID_BYTES(1), .BUILD_ID(64'h7F)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .m(ifb.master),
      .busy(busy_b), .done(done_b), .frames_sent(fs_b),
      .major(maj_b), .minor(min_b), .patch(pat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor A: scoreboard pop, stall stability, done width.
   logic       stall_a = 1'b0;
   logic [7:0] stall_d = '0;
   logic       done_prev_a = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_a     = 1'b0;
         done_prev_a = 1'b0;
      end else begin
         if (stall_a && ifa.m_valid)
            chk("stall_hold", {24'd0, ifa.m_data}, {24'd0, stall_d});
         if (ifa.m_valid && ifa.m_ready) begin
            acc_a++;
            if (exp_qa.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL a_extra: got %0h expected none", ifa.m_data);
            end else begin
               chk("a_byte", {24'd0, ifa.m_data}, {24'd0, exp_qa.pop_front()});
            end
         end
         stall_a = ifa.m_valid && !ifa.m_ready;
         stall_d = ifa.m_data;
         if (done_a) begin
            done_cnt_a++;
            chk("done_1clk", {31'd0, done_prev_a}, 32'd0);
         end
         done_prev_a = done_a;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifb.m_valid && ifb.m_ready) begin
            if (exp_qb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL b_extra: got %0h expected none", ifb.m_data);
            end else begin
               chk("b_byte", {24'd0, ifb.m_data}, {24'd0, exp_qb.pop_front()});
            end
         end
         if (done_b) done_cnt_b++;
      end
   end

   task automatic push_a();
      foreach (FR_A[i]) exp_qa.push_back(FR_A[i]);
   endtask

   task automatic pulse_a();
      @(posedge clk); #1 req_a = 1'b1;
      @(posedge clk); #1 req_a = 1'b0;
   endtask

   task automatic wait_done_a(input int target);
      int t;
      t = 0;
      while (done_cnt_a < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt_a < target) begin
         n_cmp++; n_err++;
         $display("FAIL done_a_timeout: got %0d expected %0d", done_cnt_a, target);
      end
   endtask

   task automatic wait_valid_a();
      int t;
      t = 0;
      @(negedge clk);
      while (!ifa.m_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("valid_seen", {31'd0, ifa.m_valid}, 32'd1);
   endtask

   initial begin
      int base;
      int vcnt;
      rst_n = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      ifa.m_ready = 1'b1;
      ifb.m_ready = 1'b1;
      #23;
      chk("rst_valid", {31'd0, ifa.m_valid}, 32'd0);
      chk("rst_data", {24'd0, ifa.m_data}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_done", {31'd0, done_a}, 32'd0);
      chk("rst_frames", {24'd0, fs_a}, 32'd0);
      chk("major", {24'd0, maj_a}, 32'h0B);
      chk("minor", {24'd0, min_a}, 32'h00);
      chk("patch", {24'd0, pat_a}, 32'h00);
      @(posedge clk); #1 rst_n = 1'b1;

      // 1: single frame, always ready
      push_a();
      pulse_a();
      chk("t1_latency", {31'd0, ifa.m_valid}, 32'd1);
      chk("t1_busy", {31'd0, busy_a}, 32'd1);
      wait_done_a(1);
      chk("t1_frames", {24'd0, fs_a}, 32'd1);
      @(negedge clk);
      chk("t1_idle_valid", {31'd0, ifa.m_valid}, 32'd0);
      chk("t1_idle_busy", {31'd0, busy_a}, 32'd0);

      // 2: ready toggling every cycle
      push_a();
      pulse_a();
      for (int i = 0; i < 40 && done_cnt_a < 2; i++) begin
         @(posedge clk); #1 ifa.m_ready = ~ifa.m_ready;
      end
      ifa.m_ready = 1'b1;
      wait_done_a(2);
      chk("t2_frames", {24'd0, fs_a}, 32'd2);

      // 3: reqs at byte 3 and 5 -> exactly two frames, no gap
      repeat (2) @(posedge clk);
      push_a();
      push_a();
      pulse_a();
      wait_valid_a();
      vcnt = 0;
      for (int c = 0; c < 18; c++) begin
         if (ifa.m_valid) vcnt++;
         req_a = (c == 3 || c == 5);
         @(negedge clk);
      end
      req_a = 1'b0;
      chk("t3_no_gap", vcnt, 32'd18);
      chk("t3_frames", {24'd0, fs_a}, 32'd4);
      chk("t3_idle", {31'd0, ifa.m_valid}, 32'd0);

      // 4: reset while presenting byte 4
      repeat (2) @(posedge clk);
      push_a();
      base = acc_a;
      pulse_a();
      for (int t = 0; t < 50 && acc_a < base + 4; t++) @(negedge clk);
      chk("t4_byte4", {24'd0, ifa.m_data}, 32'hDE);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_valid", {31'd0, ifa.m_valid}, 32'd0);
      chk("t4_busy", {31'd0, busy_a}, 32'd0);
      chk("t4_frames", {24'd0, fs_a}, 32'd0);
      exp_qa.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      base = done_cnt_a;
      push_a();
      pulse_a();
      chk("t4_restart", {24'd0, ifa.m_data}, 32'hA5);
      wait_done_a(base + 1);
      chk("t4_frames2", {24'd0, fs_a}, 32'd1);

      // 5: 1-byte build ID instance
      exp_qb.delete();
      foreach (FR_B[i]) exp_qb.push_back(FR_B[i]);
      @(posedge clk); #1 req_b = 1'b1;
      @(posedge clk); #1 req_b = 1'b0;
      for (int t = 0; t < 50 && done_cnt_b < 1; t++) @(negedge clk);
      chk("t5_done", done_cnt_b, 32'd1);
      chk("t5_frames", {24'd0, fs_b}, 32'd1);
      chk("t5_qempty", exp_qb.size(), 32'd0);

      // 6: 256 frames wrap the counter
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      base = done_cnt_a;
      for (int f = 0; f < 256; f++) begin
         push_a();
         pulse_a();
         wait_done_a(base + f + 1);
         if (f == 254) chk("t6_frames255", {24'd0, fs_a}, 32'd255);
      end
      chk("t6_wrap", {24'd0, fs_a}, 32'd0);
      chk("t6_dones", done_cnt_a - base, 32'd256);

      repeat (3) @(negedge clk);
      chk("qa_empty", exp_qa.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
